// File: rtl/fp16_align_stage.sv
// Two-stage FP16 operand alignment front end: magnitude ordering, exponent
// difference, smaller-significand right shift with G/R/S, and special flags.
module fp16_align_stage #(
  parameter int unsigned EXPONENT = 5,
  parameter int unsigned MANTISSA = 10,
  parameter int unsigned DWIDTH   = 1 + EXPONENT + MANTISSA
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DWIDTH-1:0]     in_a,
  input  logic [DWIDTH-1:0]     in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXPONENT-1:0]   out_exp,
  output logic [MANTISSA:0]     out_mant_l,
  output logic [MANTISSA+3:0]   out_mant_s,
  output logic                  out_sign_l,
  output logic                  out_sign_s,
  output logic                  out_eff_sub,
  output logic                  out_swapped,
  output logic                  out_nan,
  output logic                  out_inf
);

  localparam int unsigned SIGW = MANTISSA + 1;
  localparam int unsigned EXTW = MANTISSA + 4;
  localparam int unsigned MAGW = DWIDTH - 1;

  // Stage 1 state
  logic                r_s1_valid;
  logic                r_s1_sign_l;
  logic                r_s1_sign_s;
  logic [EXPONENT-1:0] r_s1_exp_l;
  logic [EXPONENT-1:0] r_s1_diff;
  logic [SIGW-1:0]     r_s1_sig_l;
  logic [SIGW-1:0]     r_s1_sig_s;
  logic                r_s1_swapped;
  logic                r_s1_nan;
  logic                r_s1_inf;

  logic                w_s2_adv;
  logic                w_swap;
  logic [DWIDTH-1:0]   w_l;
  logic [DWIDTH-1:0]   w_s;
  logic [EXPONENT-1:0] w_exp_l;
  logic [EXPONENT-1:0] w_exp_s;
  logic [EXPONENT-1:0] w_eff_l;
  logic [EXPONENT-1:0] w_eff_s;
  logic [SIGW-1:0]     w_sig_l;
  logic [SIGW-1:0]     w_sig_s;
  logic                w_a_nan;
  logic                w_b_nan;
  logic                w_a_inf;
  logic                w_b_inf;
  logic                w_nan;
  logic                w_inf;

  logic [EXTW-1:0]     w_ext;
  logic [EXTW-1:0]     w_mask;
  logic [EXTW-1:0]     w_shifted;
  logic                w_sticky;
  logic [EXTW-1:0]     w_mant_s;

  assign w_s2_adv = !out_valid || out_ready;
  assign in_ready = !r_s1_valid || w_s2_adv;

  // Stage 1 datapath: order by magnitude, effective exponents, specials
  always_comb begin
    w_swap  = in_a[MAGW-1:0] < in_b[MAGW-1:0];
    w_l     = w_swap ? in_b : in_a;
    w_s     = w_swap ? in_a : in_b;
    w_exp_l = w_l[DWIDTH-2 -: EXPONENT];
    w_exp_s = w_s[DWIDTH-2 -: EXPONENT];
    w_eff_l = (w_exp_l != '0) ? w_exp_l : EXPONENT'(1);
    w_eff_s = (w_exp_s != '0) ? w_exp_s : EXPONENT'(1);
    w_sig_l = {w_exp_l != '0, w_l[MANTISSA-1:0]};
    w_sig_s = {w_exp_s != '0, w_s[MANTISSA-1:0]};
    w_a_nan = (in_a[DWIDTH-2 -: EXPONENT] == '1) && (in_a[MANTISSA-1:0] != '0);
    w_b_nan = (in_b[DWIDTH-2 -: EXPONENT] == '1) && (in_b[MANTISSA-1:0] != '0);
    w_a_inf = (in_a[DWIDTH-2 -: EXPONENT] == '1) && (in_a[MANTISSA-1:0] == '0);
    w_b_inf = (in_b[DWIDTH-2 -: EXPONENT] == '1) && (in_b[MANTISSA-1:0] == '0);
    w_nan   = w_a_nan || w_b_nan ||
              (w_a_inf && w_b_inf && (in_a[DWIDTH-1] != in_b[DWIDTH-1]));
    w_inf   = !w_nan && (w_a_inf || w_b_inf);
  end

  // Stage 2 datapath: align smaller significand, sticky collects lost bits
  always_comb begin
    w_ext     = {r_s1_sig_s, 3'b000};
    w_mask    = (EXTW'(1) << r_s1_diff) - EXTW'(1);
    w_shifted = w_ext >> r_s1_diff;
    w_sticky  = |(w_ext & w_mask);
    if (r_s1_diff >= EXPONENT'(EXTW)) begin
      w_mant_s = {{(EXTW-1){1'b0}}, |r_s1_sig_s};
    end else begin
      w_mant_s = {w_shifted[EXTW-1:1], w_shifted[0] | w_sticky};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid   <= 1'b0;
      r_s1_sign_l  <= 1'b0;
      r_s1_sign_s  <= 1'b0;
      r_s1_exp_l   <= '0;
      r_s1_diff    <= '0;
      r_s1_sig_l   <= '0;
      r_s1_sig_s   <= '0;
      r_s1_swapped <= 1'b0;
      r_s1_nan     <= 1'b0;
      r_s1_inf     <= 1'b0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
      end
      if (in_valid && in_ready) begin
        r_s1_sign_l  <= w_l[DWIDTH-1];
        r_s1_sign_s  <= w_s[DWIDTH-1];
        r_s1_exp_l   <= w_eff_l;
        r_s1_diff    <= w_eff_l - w_eff_s;
        r_s1_sig_l   <= w_sig_l;
        r_s1_sig_s   <= w_sig_s;
        r_s1_swapped <= w_swap;
        r_s1_nan     <= w_nan;
        r_s1_inf     <= w_inf;
      end
    end
  end

  // Output register holds while downstream stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_exp     <= '0;
      out_mant_l  <= '0;
      out_mant_s  <= '0;
      out_sign_l  <= 1'b0;
      out_sign_s  <= 1'b0;
      out_eff_sub <= 1'b0;
      out_swapped <= 1'b0;
      out_nan     <= 1'b0;
      out_inf     <= 1'b0;
    end else if (w_s2_adv) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        out_exp     <= r_s1_exp_l;
        out_mant_l  <= r_s1_sig_l;
        out_mant_s  <= w_mant_s;
        out_sign_l  <= r_s1_sign_l;
        out_sign_s  <= r_s1_sign_s;
        out_eff_sub <= r_s1_sign_l ^ r_s1_sign_s;
        out_swapped <= r_s1_swapped;
        out_nan     <= r_s1_nan;
        out_inf     <= r_s1_inf;
      end
    end
  end

endmodule

// File: tb/tb_fp16_align_stage.sv
// Scoreboard bench for fp16_align_stage: directed plan vectors, stall,
// mid-flight reset and randomized traffic against an arithmetic model.
module tb_fp16_align_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_exp;
  logic [10:0] out_mant_l;
  logic [13:0] out_mant_s;
  logic        out_sign_l;
  logic        out_sign_s;
  logic        out_eff_sub;
  logic        out_swapped;
  logic        out_nan;
  logic        out_inf;

  fp16_align_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_exp(out_exp), .out_mant_l(out_mant_l), .out_mant_s(out_mant_s),
    .out_sign_l(out_sign_l), .out_sign_s(out_sign_s), .out_eff_sub(out_eff_sub),
    .out_swapped(out_swapped), .out_nan(out_nan), .out_inf(out_inf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  e;
    logic [10:0] ml;
    logic [13:0] ms;
    logic        sl;
    logic        ss;
    logic        es;
    logic        sw;
    logic        nan;
    logic        inf;
  } res_t;

  res_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   ready_mode = 0;
  res_t held;
  res_t mon_cur;
  bit   held_v = 1'b0;

  function automatic res_t mk(input logic [4:0] e, input logic [10:0] ml,
                              input logic [13:0] ms, input logic sl, input logic ss,
                              input logic es, input logic sw, input logic nan,
                              input logic inf);
    res_t r;
    r.e = e; r.ml = ml; r.ms = ms; r.sl = sl; r.ss = ss;
    r.es = es; r.sw = sw; r.nan = nan; r.inf = inf;
    return r;
  endfunction

  // Reference: field arithmetic with integer divide/modulo for the shift
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b);
    res_t r;
    logic [15:0] l, s;
    int ea, eb, fa, fb, el, es_, effl, effs, sigl, sigs, diff, ext, p, ms;
    bit swap, a_nan, b_nan, a_inf, b_inf, nan;
    ea = int'(a[14:10]); fa = int'(a[9:0]);
    eb = int'(b[14:10]); fb = int'(b[9:0]);
    a_nan = (ea == 31) && (fa != 0);
    b_nan = (eb == 31) && (fb != 0);
    a_inf = (ea == 31) && (fa == 0);
    b_inf = (eb == 31) && (fb == 0);
    nan = a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]));
    swap = int'(a[14:0]) < int'(b[14:0]);
    l = swap ? b : a;
    s = swap ? a : b;
    el = int'(l[14:10]); es_ = int'(s[14:10]);
    effl = (el == 0) ? 1 : el;
    effs = (es_ == 0) ? 1 : es_;
    sigl = ((el != 0) ? 1024 : 0) + int'(l[9:0]);
    sigs = ((es_ != 0) ? 1024 : 0) + int'(s[9:0]);
    diff = effl - effs;
    ext = sigs * 8;
    if (diff >= 14) begin
      ms = (sigs != 0) ? 1 : 0;
    end else begin
      p = 1 << diff;
      ms = (ext / p) | (((ext % p) != 0) ? 1 : 0);
    end
    r.e = 5'(effl); r.ml = 11'(sigl); r.ms = 14'(ms);
    r.sl = l[15]; r.ss = s[15]; r.es = l[15] ^ s[15]; r.sw = swap;
    r.nan = nan; r.inf = !nan && (a_inf || b_inf);
    return r;
  endfunction

  function automatic res_t actual();
    res_t r;
    r = {out_exp, out_mant_l, out_mant_s, out_sign_l, out_sign_s,
         out_eff_sub, out_swapped, out_nan, out_inf};
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  // Specials only promise their flags
  task automatic check_res(input string name, input res_t got, input res_t want);
    bit bad;
    n_vec++;
    if (want.nan || want.inf) bad = (got.nan !== want.nan) || (got.inf !== want.inf);
    else                      bad = (got !== want);
    if (bad) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: pops on every output transfer, checks held data stays put
  always @(negedge clk) begin
    if (reset) begin
      held_v = 1'b0;
    end else if (out_valid) begin
      mon_cur = actual();
      if (held_v) chk("hold_stable", {28'b0, mon_cur}, {28'b0, held});
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_output: got %h required none", mon_cur);
        end else begin
          check_res("result", mon_cur, exp_q.pop_front());
        end
        held_v = 1'b0;
      end else begin
        held = mon_cur;
        held_v = 1'b1;
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input bit use_model, input res_t want);
    bit done;
    done = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(use_model ? model(a, b) : want);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: in_ready stayed 0 required 1");
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [15:0] rand_op();
    logic [15:0] v;
    case ($urandom_range(0, 7))
      0:       v = {1'($urandom), 15'h0};
      1:       v = {1'($urandom), 5'h1F, 10'h0};
      2:       v = {1'($urandom), 5'h1F, 10'($urandom) | 10'h1};
      3:       v = {1'($urandom), 5'h0, 10'($urandom)};
      default: v = {1'($urandom), 5'($urandom_range(0, 30)), 10'($urandom)};
    endcase
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_data", {28'b0, actual()}, 64'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);

    // Directed plan vectors with hand-derived expectations
    send(16'h3C00, 16'h4000, 1'b0, mk(5'd16, 11'h400, 14'h1000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    send(16'h4000, 16'hBC00, 1'b0, mk(5'd16, 11'h400, 14'h1000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    send(16'h7BFF, 16'h0001, 1'b0, mk(5'd30, 11'h7FF, 14'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    send(16'h7C00, 16'hFC00, 1'b0, mk(5'd0, 11'h0, 14'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    send(16'h7C00, 16'h3C00, 1'b0, mk(5'd0, 11'h0, 14'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    send(16'h7E00, 16'h0000, 1'b0, mk(5'd0, 11'h0, 14'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    send(16'h0000, 16'h8000, 1'b0, mk(5'd1, 11'h0, 14'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    send(16'h4800, 16'h1BFF, 1'b0, mk(5'd18, 11'h400, 14'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    wait_drain("drain_directed");

    // Stall: four back-to-back pairs, downstream blocked three cycles
    @(negedge clk) ready_mode = 2;
    @(posedge clk); #1;
    fork
      begin
        for (int k = 0; k < 4; k++) send(rand_op(), rand_op(), 1'b1, '0);
      end
      begin : watcher
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(negedge clk);
          if (out_valid) seen = 1'b1;
        end
        chk("stall_seen_valid", {63'b0, seen}, 64'd1);
        chk("stall_in_ready", {63'b0, in_ready}, 64'd0);
        repeat (2) @(negedge clk);
        chk("stall_in_ready_held", {63'b0, in_ready}, 64'd0);
        chk("stall_pending", 64'(exp_q.size()), 64'd2);
        ready_mode = 0;
      end
    join
    wait_drain("drain_stall");

    // Reset with two pairs in flight
    send(rand_op(), rand_op(), 1'b1, '0);
    send(rand_op(), rand_op(), 1'b1, '0);
    #1;
    chk("pre_rst_out_valid", {63'b0, out_valid}, 64'd1);
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_mid_out_valid", {63'b0, out_valid}, 64'd0);
    @(negedge clk) reset = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("no_stale", 64'(cnt), 64'd0);
    @(posedge clk); #1;
    send(16'h3C00, 16'h4000, 1'b1, '0);
    chk("lat_cycle1", {63'b0, out_valid}, 64'd0);
    @(posedge clk); #1;
    chk("lat_cycle2", {63'b0, out_valid}, 64'd1);
    wait_drain("drain_reset");

    // Randomized traffic with random backpressure and input gaps
    ready_mode = 1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send(rand_op(), rand_op(), 1'b1, '0);
    end
    ready_mode = 0;
    wait_drain("drain_random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
